// File: rtl/ysyx_25060170_pkg.sv
// ysyx_25060170_pkg -- shared definitions for the write-back unit slice.
//   wbu_state_e : write-back FSM states (IDLE/REQ/RSP/WB)
//   regs_e      : write-back source select carried on in_regs
//   size_e      : access size carried on in_size
//   size_bytes  : access size in bytes, clipped to the datapath width
//   is_misaligned: lane offset not a multiple of the access size
package ysyx_25060170_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_WB
  } wbu_state_e;

  typedef enum logic [1:0] {
    REGS_ALU  = 2'd0,
    REGS_MEM  = 2'd1,
    REGS_PC4  = 2'd2,
    REGS_ZERO = 2'd3
  } regs_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  // A dword access on a 32-bit datapath degrades to a full-width access.
  function automatic int unsigned size_bytes(logic [1:0] size, int unsigned nb);
    int unsigned n;
    case (size)
      SIZE_B:  n = 1;
      SIZE_H:  n = 2;
      SIZE_W:  n = 4;
      SIZE_D:  n = 8;
      default: n = 1;
    endcase
    return (n > nb) ? nb : n;
  endfunction

  function automatic logic is_misaligned(int unsigned off, logic [1:0] size, int unsigned nb);
    return (off % size_bytes(size, nb)) != 0;
  endfunction

endpackage

// File: rtl/ysyx_25060170_wbu_mc_if.sv
// ysyx_25060170_wbu_mc_if -- bundle of the write-back unit's bus signals.
//   in_*          : instruction handshake and fields from EXU
//   mem_req_*     : memory request channel (valid/ready, addr, wen, wdata, wstrb)
//   mem_rsp_*     : memory response (valid, data)
//   reg_write_*_o : register file write port; wb_done_o, err_o status
// Modports: slave = the write-back unit, master = its environment.
interface ysyx_25060170_wbu_mc_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_alu;
  logic [XLEN-1:0]    in_rs2;
  logic [RADDR_W-1:0] in_rd;
  logic [1:0]         in_regs;
  logic               in_regw;
  logic               in_memwr;
  logic [1:0]         in_size;
  logic               in_unsigned;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_req_wen;
  logic [XLEN-1:0]    mem_req_wdata;
  logic [XLEN/8-1:0]  mem_req_wstrb;
  logic               mem_rsp_valid;
  logic [XLEN-1:0]    mem_rsp_data;

  logic [XLEN-1:0]    reg_write_data_o;
  logic [RADDR_W-1:0] reg_write_addr_o;
  logic               reg_write_en_o;
  logic               wb_done_o;
  logic               err_o;

  modport slave (
    input  in_valid, in_pc, in_alu, in_rs2, in_rd, in_regs, in_regw, in_memwr,
           in_size, in_unsigned, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, reg_write_data_o, reg_write_addr_o, reg_write_en_o,
           wb_done_o, err_o
  );

  modport master (
    output in_valid, in_pc, in_alu, in_rs2, in_rd, in_regs, in_regw, in_memwr,
           in_size, in_unsigned, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, reg_write_data_o, reg_write_addr_o, reg_write_en_o,
           wb_done_o, err_o
  );
endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// ysyx_25060170_lsu_align -- combinational lane steering for loads/stores.
//   off     : byte lane offset within the aligned word
//   size    : access size (byte/half/word/dword)
//   uns     : zero-extend loads when set, sign-extend otherwise
//   st_data : store source; low size bytes replicated across all lanes -> wdata
//   wstrb   : size bytes from off, truncated at the word boundary
//   ld_raw  : raw memory word; ld_data = extracted and extended load value
module ysyx_25060170_lsu_align
  import ysyx_25060170_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                size,
  input  logic                      uns,
  input  logic [XLEN-1:0]           st_data,
  input  logic [XLEN-1:0]           ld_raw,
  output logic [XLEN-1:0]           wdata,
  output logic [XLEN/8-1:0]         wstrb,
  output logic [XLEN-1:0]           ld_data
);
  localparam int unsigned NB = XLEN / 8;

  int unsigned     n;
  logic [XLEN-1:0] shifted;

  always_comb begin
    n       = size_bytes(size, NB);
    // Bytes past the word end shift in as zero, so a truncated load
    // takes its sign from a zero byte.
    shifted = ld_raw >> {off, 3'b000};
    wdata   = '0;
    wstrb   = '0;
    ld_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wdata[i*8 +: 8] = st_data[(i % n)*8 +: 8];
      wstrb[i]        = (i >= 32'(off)) && (i < 32'(off) + n);
      if (i < n)
        ld_data[i*8 +: 8] = shifted[i*8 +: 8];
      else
        ld_data[i*8 +: 8] = (uns || !shifted[n*8-1]) ? 8'h00 : 8'hFF;
    end
  end
endmodule

// File: rtl/ysyx_25060170_wbu_mc.sv
// ysyx_25060170_wbu_mc -- multi-cycle write-back unit with memory access.
// Ports: clk, rst (async, active-high), bus (ysyx_25060170_wbu_mc_if.slave):
//   accepts one instruction from EXU, issues at most one memory request,
//   waits for the response, then writes the result back for one cycle.
// Option: YSYX_25060170_MISALIGN_CHK_EN -- misaligned accesses skip memory
//   and report err_o in the write-back cycle; otherwise err_o is 0.
module ysyx_25060170_wbu_mc
  import ysyx_25060170_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_25060170_wbu_mc_if.slave  bus
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  wbu_state_e         state, state_nxt;
  logic [XLEN-1:0]    pc_q, alu_q, rs2_q, ld_q;
  logic [RADDR_W-1:0] rd_q;
  logic [1:0]         regs_q, size_q;
  logic               regw_q, memwr_q, uns_q;
  logic               err_q, acc_err;
  logic               accept, acc_mem;
  logic [XLEN-1:0]    al_wdata, al_ldata;
  logic [NB-1:0]      al_wstrb;

  assign accept  = (state == ST_IDLE) && bus.in_valid;
  assign acc_mem = bus.in_memwr || (bus.in_regs == REGS_MEM);

`ifdef YSYX_25060170_MISALIGN_CHK_EN
  assign acc_err = acc_mem && is_misaligned(32'(bus.in_alu[OFF_W-1:0]), bus.in_size, NB);
`else
  assign acc_err = 1'b0;
`endif

  ysyx_25060170_lsu_align #(.XLEN(XLEN)) u_align (
    .off     (alu_q[OFF_W-1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .st_data (rs2_q),
    .ld_raw  (bus.mem_rsp_data),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .ld_data (al_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.in_ready       = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.wb_done_o      = 1'b0;
    bus.reg_write_en_o = 1'b0;
    bus.err_o          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          state_nxt = (acc_mem && !acc_err) ? ST_REQ : ST_WB;
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (bus.mem_rsp_valid) state_nxt = ST_WB;
      end
      ST_WB: begin
        bus.wb_done_o      = 1'b1;
        bus.reg_write_en_o = regw_q && (rd_q != '0) && !err_q;
        bus.err_o          = err_q;
        state_nxt          = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      alu_q   <= '0;
      rs2_q   <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      regs_q  <= '0;
      size_q  <= '0;
      regw_q  <= 1'b0;
      memwr_q <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= bus.in_pc;
        alu_q   <= bus.in_alu;
        rs2_q   <= bus.in_rs2;
        rd_q    <= bus.in_rd;
        regs_q  <= bus.in_regs;
        size_q  <= bus.in_size;
        regw_q  <= bus.in_regw;
        memwr_q <= bus.in_memwr;
        uns_q   <= bus.in_unsigned;
      end
      if (state == ST_RSP && bus.mem_rsp_valid) ld_q <= al_ldata;
    end
  end

`ifdef YSYX_25060170_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= acc_err;
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.mem_req_addr  = {alu_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.mem_req_wen   = memwr_q;
  assign bus.mem_req_wdata = al_wdata;
  assign bus.mem_req_wstrb = memwr_q ? al_wstrb : '0;
  assign bus.reg_write_addr_o = rd_q;

  // A store selecting the memory source writes back zero, not stale load data.
  always_comb begin
    bus.reg_write_data_o = '0;
    case (regs_q)
      REGS_ALU: bus.reg_write_data_o = alu_q;
      REGS_MEM: bus.reg_write_data_o = memwr_q ? '0 : ld_q;
      REGS_PC4: bus.reg_write_data_o = pc_q + XLEN'(4);
      default:  bus.reg_write_data_o = '0;
    endcase
  end
endmodule

// File: tb/tb_ysyx_25060170_wbu_mc.sv
module tb_ysyx_25060170_wbu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  ysyx_25060170_wbu_mc_if #(.XLEN(32), .RADDR_W(5)) bus ();
  ysyx_25060170_wbu_mc #(.XLEN(32), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] v, mask;
    int unsigned n;
    n    = nbytes(size);
    mask = (64'd1 << (n * 8)) - 64'd1;
    v    = (64'(word) >> (off * 8)) & mask;
    if (!uns && v[n*8-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] st_wdata(input logic [31:0] rs2, input logic [1:0] size);
    case (nbytes(size))
      1:       return {4{rs2[7:0]}};
      2:       return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic [3:0] st_wstrb(input logic [1:0] off, input logic [1:0] size);
    logic [7:0] t;
    t = 8'((32'd1 << nbytes(size)) - 1) << off;
    return t[3:0];
  endfunction

  function automatic logic [31:0] wb_val(input logic [1:0] regs, input logic memwr,
                                         input logic [31:0] alu, input logic [31:0] pc,
                                         input logic [31:0] rsp, input logic [1:0] size,
                                         input logic uns);
    case (regs)
      2'd0:    return alu;
      2'd1:    return memwr ? 32'd0 : load_val(rsp, alu[1:0], size, uns);
      2'd2:    return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // ---- one instruction end to end -----------------------------------------
  task automatic do_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [1:0] regs, input logic regw,
                          input logic memwr, input logic [1:0] size, input logic uns,
                          input int unsigned rdly, input int unsigned rsp_dly,
                          input logic [31:0] rsp);
    logic        is_mem, mis;
    logic [31:0] exp_data;
    is_mem = memwr || (regs == 2'd1);
`ifdef YSYX_25060170_MISALIGN_CHK_EN
    mis = is_mem && ((alu[1:0] % nbytes(size)) != 0);
`else
    mis = 1'b0;
`endif
    exp_data = wb_val(regs, memwr, alu, pc, rsp, size, uns);
    bus.in_pc = pc; bus.in_alu = alu; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_regs = regs; bus.in_regw = regw; bus.in_memwr = memwr;
    bus.in_size = size; bus.in_unsigned = uns; bus.in_valid = 1'b1;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_pc = $urandom; bus.in_alu = $urandom; bus.in_rs2 = $urandom;
    bus.in_rd = 5'($urandom); bus.in_regs = 2'($urandom); bus.in_size = 2'($urandom);
    bus.in_regw = 1'($urandom); bus.in_memwr = 1'($urandom); bus.in_unsigned = 1'($urandom);
    if (is_mem && !mis) begin
      for (int unsigned c = 0; c <= rdly; c++) begin
        check("req_valid", bus.mem_req_valid, 1);
        check("req_addr", bus.mem_req_addr, {alu[31:2], 2'b00});
        check("req_wen", bus.mem_req_wen, memwr);
        check("in_ready_busy", bus.in_ready, 0);
        check("req_wstrb", bus.mem_req_wstrb, memwr ? st_wstrb(alu[1:0], size) : 4'b0000);
        if (memwr) check("req_wdata", bus.mem_req_wdata, st_wdata(rs2, size));
        if (c == rdly) bus.mem_req_ready = 1'b1;
        else begin
          bus.mem_req_ready = 1'b0;
          bus.mem_rsp_valid = 1'b1;          // must be ignored outside RSP
          bus.mem_rsp_data  = $urandom;
        end
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
      end
      check("req_dropped", bus.mem_req_valid, 0);
      for (int unsigned c = 0; c <= rsp_dly; c++) begin
        check("wb_wait", bus.wb_done_o, 0);
        if (c == rsp_dly) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = rsp;
        end
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
      end
    end
    check("wb_done", bus.wb_done_o, 1);
    check("wb_en", bus.reg_write_en_o, regw && (rd != 0) && !mis);
    check("wb_addr", bus.reg_write_addr_o, rd);
    check("wb_err", bus.err_o, mis);
    check("wb_no_req", bus.mem_req_valid, 0);
    if (!mis) check("wb_data", bus.reg_write_data_o, exp_data);
    @(posedge clk); #1;
    check("post_done", bus.wb_done_o, 0);
    check("post_en", bus.reg_write_en_o, 0);
    check("post_ready", bus.in_ready, 1);
    if (!mis) check("post_data_hold", bus.reg_write_data_o, exp_data);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_alu = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_regs = '0; bus.in_regw = 1'b0; bus.in_memwr = 1'b0; bus.in_size = '0;
    bus.in_unsigned = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;

    // reset state
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_wstrb", bus.mem_req_wstrb, 0);
    check("rst_wdata", bus.mem_req_wdata, 0);
    check("rst_addr", bus.mem_req_addr, 0);
    check("rst_wb_data", bus.reg_write_data_o, 0);
    check("rst_wb_addr", bus.reg_write_addr_o, 0);
    check("rst_wb_en", bus.reg_write_en_o, 0);
    check("rst_wb_done", bus.wb_done_o, 0);
    check("rst_err", bus.err_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU op, load byte signed/unsigned, store half, stalled store
    do_instr(32'h0, 32'h1234, 32'h0, 5'd5, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 0, 0, 32'h0);
    do_instr(32'h80000100, 32'h80000003, 32'h0, 5'd6, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 32'h80FFFFFF);
    check("lb_value", bus.reg_write_data_o, 32'hFFFFFF80);
    do_instr(32'h80000104, 32'h80000003, 32'h0, 5'd6, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 0, 0, 32'h80FFFFFF);
    check("lbu_value", bus.reg_write_data_o, 32'h00000080);
    do_instr(32'h80000108, 32'h80000002, 32'h0000ABCD, 5'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 0, 0, 32'h0);
    do_instr(32'h8000010C, 32'h80000002, 32'h0000ABCD, 5'd9, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 3, 1, 32'h0);
    // store with memory source: write back zero
    do_instr(32'h80000110, 32'h80000004, 32'h11223344, 5'd3, 2'd1, 1'b1, 1'b1, 2'd2, 1'b0, 1, 2, 32'hDEADBEEF);
    // PC+4 wraps
    do_instr(32'hFFFFFFFE, 32'h5, 32'h0, 5'd1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 32'h0);
    // rd = 0 never writes
    do_instr(32'h0, 32'h77, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 32'h0);
`ifdef YSYX_25060170_MISALIGN_CHK_EN
    do_instr(32'h80000200, 32'h80000002, 32'h0, 5'd4, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 0, 0, 32'h0);
    check("misalign_err_cleared", bus.err_o, 0);
`endif

    // reset while REQ drops the request immediately
    bus.in_pc = 32'h80000300; bus.in_alu = 32'h80000008; bus.in_rs2 = 32'hCAFEF00D; bus.in_rd = 5'd8;
    bus.in_regs = 2'd0; bus.in_regw = 1'b1; bus.in_memwr = 1'b1; bus.in_size = 2'd2;
    bus.in_unsigned = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("r25_req_before", bus.mem_req_valid, 1);
    rst = 1'b1; #1;
    check("r25_req_dropped", bus.mem_req_valid, 0);
    check("r25_wstrb_clear", bus.mem_req_wstrb, 0);
    check("r25_in_ready", bus.in_ready, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("r25_no_wb", bus.wb_done_o, 0);

    // reset while RSP, then a late response
    bus.in_pc = 32'h80000400; bus.in_alu = 32'h80000010; bus.in_rd = 5'd7; bus.in_regs = 2'd1;
    bus.in_regw = 1'b1; bus.in_memwr = 1'b0; bus.in_size = 2'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    check("r34_in_rsp", bus.in_ready, 0);
    rst = 1'b1; #1;
    check("r34_in_ready", bus.in_ready, 1);
    check("r34_addr_clear", bus.reg_write_addr_o, 0);
    #1 rst = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h12345678;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    check("r34_no_done", bus.wb_done_o, 0);
    check("r34_no_en", bus.reg_write_en_o, 0);
    check("r34_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    check("r34_still_idle", bus.wb_done_o, 0);

    // randomized instructions against the model
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  regs, size;
      logic        memwr;
      logic [31:0] alu;
      regs  = 2'($urandom_range(0, 3));
      memwr = ($urandom_range(0, 2) == 0);
      size  = 2'($urandom_range(0, 3));
      alu   = (memwr || regs == 2'd1) ? (32'h80000000 | 32'($urandom_range(0, 4095))) : $urandom;
      do_instr($urandom, alu, $urandom, 5'($urandom), regs, 1'($urandom), memwr, size,
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_wbu_mc.md
YSYX_25060170_WBU_MC -- requirements
Module: ysyx_25060170_wbu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1  instruction handshake from EXU.
REQ-006 SHALL have ports in_pc, in_alu, in_rs2  in  XLEN each  PC, ALU result/address, store data.
REQ-007 SHALL have ports in_rd in RADDR_W; in_regs in 2 (0 ALU, 1 MEM, 2 PC+4, 3 zero); in_regw in 1; in_memwr in 1.
REQ-008 SHALL have ports in_size in 2 (0 byte, 1 half, 2 word, 3 dword) and in_unsigned in 1  load extension.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out XLEN, mem_req_wen out 1, mem_req_wdata out XLEN, mem_req_wstrb out XLEN/8.
REQ-010 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in XLEN.
REQ-011 SHALL have ports reg_write_data_o out XLEN, reg_write_addr_o out RADDR_W, reg_write_en_o out 1, wb_done_o out 1, err_o out 1.

Function
REQ-012 SHALL implement FSM IDLE, REQ, RSP, WB; in_ready SHALL be 1 only in IDLE.
REQ-013 On in_valid&in_ready SHALL latch all in_* fields; go REQ if in_memwr or in_regs==1, else WB.
REQ-014 In REQ SHALL assert mem_req_valid with addr/wen/wdata/wstrb held stable until mem_req_ready; then go RSP.
REQ-015 mem_req_addr SHALL be in_alu aligned down to XLEN/8 bytes; lane offset = in_alu low log2(XLEN/8) bits.
REQ-016 Stores SHALL replicate in_rs2 low bytes across lanes and set wstrb bits for size bytes starting at lane offset.
REQ-017 In RSP SHALL wait for mem_rsp_valid (earliest the cycle after request handshake); then go WB; rsp in any other state SHALL be ignored.
REQ-018 Loads SHALL extract size bytes at lane offset, zero-extend if in_unsigned else sign-extend, register the result.
REQ-019 Write data SHALL be ALU result, loaded data, in_pc+4 (XLEN-bit, wrap modulo 2^XLEN), or 0 per in_regs.
REQ-020 In WB for exactly one cycle: reg_write_en_o = in_regw & (rd!=0) & ~err; wb_done_o = 1; then IDLE.
REQ-021 Non-memory instruction: accept cycle N, WB cycle N+1; load/store with zero-wait memory: WB at N+3.
REQ-022 Store with in_regs==1 SHALL perform store only and write back 0.
REQ-023 Outside WB, reg_write_en_o and wb_done_o SHALL be 0; reg_write_data_o/addr_o SHALL hold last latched values.

Reset
REQ-024 rst SHALL immediately force IDLE, clear all latched fields, all outputs 0 except in_ready=1.
REQ-025 rst mid-REQ/RSP SHALL drop mem_req_valid at once and suppress the pending write-back.

Configuration
REQ-026 With YSYX_25060170_MISALIGN_CHK_EN defined, access whose offset is not size-aligned SHALL skip REQ/RSP, go WB with err_o=1 for that cycle and no register write.
REQ-027 Without the macro, err_o SHALL be constant 0 and misaligned accesses use lanes truncated at the word boundary.

Structure
REQ-028 Package ysyx_25060170_pkg SHALL hold the FSM state enum, regS and size encodings.
REQ-029 Sub-module ysyx_25060170_lsu_align SHALL contain combinational lane extract/extend and wstrb/wdata generation.

Verification
REQ-030 ALU op in_alu=0x1234, rd=5, regs=0 -> WB next cycle, data 0x1234, addr 5, en 1, wb_done 1.
REQ-031 lb addr 0x80000003, rsp 0x80FFFFFF -> data 0xFFFFFF80; lbu -> 0x00000080.
REQ-032 sh addr 0x80000002, rs2 0xABCD -> wstrb 4'b1100, wdata 0xABCDABCD, addr 0x80000000; no reg write.
REQ-033 mem_req_ready low 3 cycles -> request fields stable, in_ready 0 throughout.
REQ-034 rst pulsed in RSP, then late mem_rsp_valid -> no reg_write_en_o, FSM IDLE.
REQ-035 With macro, lw addr 0x80000002 -> no mem_req_valid, err_o 1, reg_write_en_o 0.
